prog_counter: RTL

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/prog_counter_if.sv | 41 ++++
 rtl/prog_counter.sv | 100 ++++++++++
 2 files changed

// File: rtl/prog_counter_if.sv
// Bus interface for prog_counter: control inputs, count/status outputs.
// PROG_COUNTER_PRESCALE_EN adds the prescale divider input.
interface prog_counter_if #(
    parameter int unsigned WIDTH = 8
`ifdef PROG_COUNTER_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE_W = 4
`endif
);
    logic             en;
    logic             up;
    logic             start;
    logic             stop;
    logic             oneshot;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
`ifdef PROG_COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale;
`endif
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             busy;
    logic             done;

    modport master (
        output en, up, start, stop, oneshot, load, load_val, limit,
`ifdef PROG_COUNTER_PRESCALE_EN
        output prescale,
`endif
        input  count, wrap, busy, done
    );

    modport slave (
        input  en, up, start, stop, oneshot, load, load_val, limit,
`ifdef PROG_COUNTER_PRESCALE_EN
        input  prescale,
`endif
        output count, wrap, busy, done
    );
endinterface

// File: rtl/prog_counter.sv
// Programmable up/down counter with IDLE/RUN/HALT control FSM and optional
// oneshot halt on wrap. Define PROG_COUNTER_PRESCALE_EN to add a tick
// prescaler (tick every prescale+1 enabled RUN cycles).
module prog_counter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input logic           clk,
    input logic           rst_n,
    prog_counter_if.slave bus
);

    if (WIDTH < 2 || PRESCALE_W < 1) begin : g_bad_params
        $error("prog_counter: WIDTH must be >= 2 and PRESCALE_W >= 1");
    end

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             run;
    logic             tick;
    logic             at_bound;
    logic             wrap;

    assign run = (state_q == StRun);

`ifdef PROG_COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] div_q, div_d;

    assign tick = run & bus.en & (div_q == bus.prescale);

    // Divider next state: counts enabled RUN cycles, clears on tick or any strobe
    always_comb begin
        div_d = div_q;
        if (bus.start || bus.stop || bus.load) begin
            div_d = '0;
        end else if (run && bus.en) begin
            div_d = tick ? '0 : div_q + PRESCALE_W'(1);
        end
    end

    // Divider register
    always_ff @(posedge clk) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end
`else
    assign tick = run & bus.en;
`endif

    // Up wraps at or above limit so an over-range load_val still wraps to 0
    assign at_bound = bus.up ? (count_q >= bus.limit) : (count_q == '0);
    assign wrap     = tick & at_bound & ~bus.load;

    // Count next state: load beats tick
    always_comb begin
        count_d = count_q;
        if (bus.load) begin
            count_d = bus.load_val;
        end else if (tick) begin
            if (bus.up) count_d = at_bound ? '0 : count_q + WIDTH'(1);
            else        count_d = at_bound ? bus.limit : count_q - WIDTH'(1);
        end
    end

    // FSM next state: stop has priority over start
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.start && !bus.stop) state_d = StRun;
            StRun: begin
                if (bus.stop)                 state_d = StIdle;
                else if (wrap && bus.oneshot) state_d = StHalt;
            end
            StHalt: begin
                if (bus.stop)       state_d = StIdle;
                else if (bus.start) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and count registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap;
    assign bus.busy  = run;
    assign bus.done  = (state_q == StHalt);

endmodule
